// File: rtl/alu_seq_core.sv
// alu_seq_core: parametrised sequential ALU with start/busy/done handshake and shift-add multiplier
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             start,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] final1,
  output logic [WIDTH-1:0] final2,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);
  localparam int SW = $clog2(WIDTH);
  localparam int M = WIDTH - 1;
  localparam logic [1:0] IDLE = 2'b00, EXEC = 2'b01, MUL = 2'b10, DONE = 2'b11;
  localparam logic [6:0] OP_MUL = 7'b0000010;
  logic [1:0] r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_out, w_a_nxt, w_b_nxt, w_res;
  logic [6:0] r_op;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
  logic [WIDTH:0] w_add, w_sub, w_mul_sum;
  logic [SW-1:0] r_cnt;
  logic r_carry, r_zero, r_ovf, r_err, w_err, w_c, w_v, w_mul_last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else if (on) r_state <= w_next;
  always_comb begin
    w_next = !on ? r_state :
             r_state == IDLE ? (start ? (out_sel == OP_MUL ? MUL : EXEC) : IDLE) :
             r_state == EXEC ? DONE :
             r_state == MUL  ? (w_mul_last ? DONE : MUL) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  assign w_a_nxt = in_sel == 3'b010 ? num1 : in_sel == 3'b001 ? '0 : r_a;
  assign w_b_nxt = in_sel == 3'b010 ? num2 : in_sel == 3'b001 ? '0 : r_b;
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  assign w_err = !$onehot(r_op);
  assign w_res = w_err ? '0 : r_op[6] ? w_add[M:0] : r_op[5] ? w_sub[M:0] :
                 r_op[4] ? r_a & r_b : r_op[3] ? r_a | r_b : r_op[2] ? r_a ^ r_b : r_a << r_b[SW-1:0];
  assign w_c = !w_err && (r_op[6] ? w_add[WIDTH] : r_op[5] && w_sub[WIDTH]);
  assign w_v = !w_err && (r_op[6] ? (r_a[M] == r_b[M] && w_add[M] != r_a[M]) :
                          r_op[5] && (r_a[M] != r_b[M] && w_sub[M] != r_a[M]));
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[M:1]};
  assign w_mul_last = r_cnt == SW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
      r_out <= '0;
      r_op <= '0;
      r_prod <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_zero <= 1'b0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else if (on) begin
      if (r_state == IDLE) begin
        r_a <= w_a_nxt;
        r_b <= w_b_nxt;
        if (start) begin
          r_op <= out_sel;
          r_prod <= {{WIDTH{1'b0}}, w_b_nxt};
          r_cnt <= '0;
        end
      end
      if (r_state == EXEC) begin
        r_out <= w_res;
        r_carry <= w_c;
        r_ovf <= w_v;
        r_err <= w_err;
        r_zero <= w_res == '0;
      end
      if (r_state == MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_out <= w_prod_nxt[M:0];
          r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
          r_ovf <= 1'b0;
          r_err <= 1'b0;
          r_zero <= w_prod_nxt[M:0] == '0;
        end
      end
    end
  assign final1 = r_a;
  assign final2 = r_b;
  assign out = r_out;
  assign carry = r_carry;
  assign zero = r_zero;
  assign ovf = r_ovf;
  assign err = r_err;
  assign currState = r_state;
  assign nextState = w_next;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed scoreboard bench for alu_seq_core at WIDTH=8
module tb_alu_seq_core;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, on = 1'b1, start = 1'b0;
  logic [2:0] in_sel = 3'b100;
  logic [W-1:0] num1 = '0, num2 = '0;
  logic [6:0] out_sel = 7'b1000000;
  logic [W-1:0] final1, final2, out;
  logic carry, zero, ovf, err, busy, done;
  logic [1:0] currState, nextState;
  int checks = 0, failures = 0;
  typedef struct {
    logic [W-1:0] o;
    logic c, z, v, e;
    int lat;
  } exp_t;
  exp_t sb[$];
  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .in_sel(in_sel),
    .num1(num1), .num2(num2), .out_sel(out_sel),
    .final1(final1), .final2(final2), .out(out),
    .carry(carry), .zero(zero), .ovf(ovf), .err(err),
    .busy(busy), .done(done), .currState(currState), .nextState(nextState)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] is, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [6:0] sel, input logic [W-1:0] eo, input logic ec, input logic ev,
                        input logic ee, input int lat, input int pulse_at, input int off_at, input int off_len);
    exp_t e, g;
    int n;
    logic [1:0] frz;
    e.o = eo; e.c = ec; e.z = (eo == '0); e.v = ev; e.e = ee; e.lat = lat;
    frz = 2'b00;
    in_sel = is; num1 = a; num2 = b; out_sel = sel; start = 1'b1;
    #1 chk({tag, ":next"}, nextState, sel == 7'b0000010 ? 2 : 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; in_sel = 3'b100; num1 = '1; num2 = '1;
    chk({tag, ":busy"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      start = (n == pulse_at);
      on = !(n >= off_at && n < off_at + off_len);
      if (n == off_at) frz = currState;
      @(negedge clk);
      n++;
      if (off_len > 0 && n == off_at + off_len) chk({tag, ":frozen"}, currState, frz);
    end
    start = 1'b0; on = 1'b1;
    g = sb.pop_front();
    chk({tag, ":done"}, done, 1);
    chk({tag, ":lat"}, n, g.lat);
    chk({tag, ":out"}, out, g.o);
    chk({tag, ":carry"}, carry, g.c);
    chk({tag, ":zero"}, zero, g.z);
    chk({tag, ":ovf"}, ovf, g.v);
    chk({tag, ":err"}, err, g.e);
    @(negedge clk);
    chk({tag, ":done_drop"}, done, 0);
    chk({tag, ":idle"}, {busy, currState}, 0);
  endtask
  initial begin
    logic seen;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst:state", currState, 0);
    chk("rst:out", out, 0);
    chk("rst:ops", {final1, final2}, 0);
    chk("rst:flags", {carry, zero, ovf, err, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    run_op("add", 3'b010, 8'h57, 8'h1A, 7'b1000000, 8'h71, 0, 0, 0, 1, -1, -1, 0);
    run_op("add_ovf", 3'b010, 8'h7F, 8'h01, 7'b1000000, 8'h80, 0, 1, 0, 1, -1, -1, 0);
    run_op("sub", 3'b010, 8'h02, 8'h04, 7'b0100000, 8'hFE, 1, 0, 0, 1, -1, -1, 0);
    run_op("sub_clr", 3'b001, 8'h33, 8'h44, 7'b0100000, 8'h00, 0, 0, 0, 1, -1, -1, 0);
    chk("clr:ops", {final1, final2}, 0);
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A;
    @(negedge clk);
    in_sel = 3'b100;
    chk("idle_load:a", final1, 8'h57);
    chk("idle_load:b", final2, 8'h1A);
    chk("idle_load:res", {out, zero, busy}, {8'h00, 1'b1, 1'b0});
    run_op("xor_persist", 3'b100, 8'hFF, 8'hFF, 7'b0000100, 8'h4D, 0, 0, 0, 1, -1, -1, 0);
    chk("persist:ops", {final1, final2}, {8'h57, 8'h1A});
    run_op("mul", 3'b010, 8'h57, 8'h1A, 7'b0000010, 8'hD6, 1, 0, 0, 8, 3, -1, 0);
    run_op("mul_off", 3'b100, 8'h00, 8'h00, 7'b0000010, 8'hD6, 1, 0, 0, 11, -1, 2, 3);
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b0000010; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_sel = 3'b100;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid:state", currState, 0);
    chk("rst_mid:out", {out, carry, zero, ovf, err}, 0);
    chk("rst_mid:ops", {final1, final2}, 0);
    chk("rst_mid:hs", {busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rst_mid:no_done", seen, 0);
    run_op("illegal", 3'b010, 8'h55, 8'h0F, 7'b0000011, 8'h00, 0, 0, 1, 1, -1, -1, 0);
    run_op("shl", 3'b010, 8'h03, 8'h02, 7'b0000001, 8'h0C, 0, 0, 0, 1, -1, -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
